rin_window_sampler: RTL and testbench
=====================================

Name: rin_window_sampler

Overview:
- Sits directly upstream of the 10-bit red-input PIO.
- Consumes the camera pixel stream (Avalon-ST style, 30-bit RGB, R in [29:20]) and averages the R channel over a fixed rectangular window once per frame.
- Publishes the 10-bit average on rin_out, which feeds the PIO's in_port.
- rin_out changes at most once per frame and atomically, so downstream edge capture sees one clean transition per frame.

Parameters:
- IMG_W, 640: active pixels per line.
- IMG_H, 480: active lines per frame.
- WIN_X0, 304: first window column.
- WIN_Y0, 224: first window row.
- WIN_LOG2W, 5: window width is 2^WIN_LOG2W columns.
- WIN_LOG2H, 5: window height is 2^WIN_LOG2H rows.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- capture_en  input  1  frame capture enable.
- pix_data  input  30  pixel {R[29:20], G[19:10], B[9:0]}.
- pix_valid  input  1  beat valid.
- pix_sop  input  1  first pixel of frame.
- pix_eop  input  1  last pixel of frame.
- pix_ready  output  1  sink ready.
- rin_out  output  10  latest window R average, to PIO in_port.
- frame_done  output  1  one-cycle pulse when rin_out is updated.
- frame_cnt  output  16  published-frame counter, wraps 0xFFFF->0.
- frame_err  output  1  one-cycle pulse on malformed frame (optional feature only).

Behaviour:
- Reset (asynchronous, active-high):
  - State goes to IDLE; acc, x, y are cleared.
  - rin_out=0, frame_done=0, frame_cnt=0, frame_err=0.
  - pix_ready=0 while reset is asserted.
- Beat accepted: pix_valid & pix_ready.
- pix_ready=1 in IDLE and ACTIVE, 0 in PUBLISH.
- Accumulator width: 10+WIN_LOG2W+WIN_LOG2H bits, unsigned. Cannot overflow.
- x and y counters are 12 bits each.
- State IDLE:
  - Accepted beat with pix_sop & capture_en: x=1, y=0, acc = R if (0,0) is in the window, else 0; go to ACTIVE.
  - If that beat also has pix_eop (1-pixel frame): go to PUBLISH instead.
  - Beats without sop, or with capture_en=0: accepted and dropped.
- State ACTIVE (per accepted beat, pixel at (x,y)):
  - Add R to acc iff WIN_X0<=x<WIN_X0+2^WIN_LOG2W and WIN_Y0<=y<WIN_Y0+2^WIN_LOG2H.
  - Advance counters: if x==IMG_W-1 then x=0, y=y+1, else x=x+1.
  - Beat with pix_eop (after the add): go to PUBLISH.
  - Beat with pix_sop: abandon the current frame and restart as in IDLE. That beat is pixel (0,0); no publish occurs.
  - capture_en deasserting mid-frame has no effect; the frame completes.
- State PUBLISH (exactly one cycle):
  - At the next edge: rin_out <= acc >> (WIN_LOG2W+WIN_LOG2H) (truncating), frame_done=1 for one cycle, frame_cnt += 1.
  - Return to IDLE.
- Latency: eop beat accepted at edge N; rin_out and frame_done update at edge N+1.
- rin_out holds its value between publishes.
- Beats arriving while pix_ready=0 are held by the source (standard valid/ready rule: pix_valid and pix_data stable until accepted).
- Reset asserted mid-frame: the partial frame is discarded; rin_out returns to 0.

Optional Feature:
- Macro: RIN_FRAME_CHECK_EN.
- Defined:
  - On the eop beat, check that it is pixel (IMG_W-1, IMG_H-1).
  - If not: skip PUBLISH, pulse frame_err for one cycle (at edge N+1), leave rin_out and frame_cnt unchanged, return to IDLE.
  - A pix_sop restart in ACTIVE also pulses frame_err.
- Not defined: frame_err is tied to 0; every eop publishes regardless of pixel count.

Test Plan:
- Reset release, then one full frame with R=100 for all pixels -> rin_out=100 one cycle after the eop beat; frame_done pulses once; frame_cnt=1.
- Frame with R = x[9:0] -> window average (304..335) truncates to rin_out=319.
- Two frames: R=0x3FF, then R=0 -> rin_out goes 1023 then 0; exactly two frame_done pulses; frame_cnt=2.
- Random pix_valid gaps (~50% duty) with R=512 -> rin_out=512; no beat lost during the PUBLISH cycle where pix_ready=0.
- capture_en=0 at sop -> frame ignored, rin_out unchanged. Drop capture_en mid-frame with R=200 -> that frame still publishes 200.
- With RIN_FRAME_CHECK_EN, eop at pixel (100,10) -> frame_err pulse, no frame_done, rin_out and frame_cnt unchanged. Without the macro, the same stimulus publishes the truncated partial-window average.

Source files
------------

// File: rtl/rin_window_sampler_if.sv
// Pixel stream bundle feeding rin_window_sampler.
// Avalon-ST style: 30-bit RGB beat (R in [29:20]) with valid/ready and frame markers.
interface rin_window_sampler_if;
  logic [29:0] pix_data;
  logic        pix_valid;
  logic        pix_sop;
  logic        pix_eop;
  logic        pix_ready;

  modport master (
    output pix_data, pix_valid, pix_sop, pix_eop,
    input  pix_ready
  );

  modport slave (
    input  pix_data, pix_valid, pix_sop, pix_eop,
    output pix_ready
  );
endinterface

// File: rtl/rin_window_sampler.sv
// rin_window_sampler: averages the R channel of the camera stream over a fixed
// 2^WIN_LOG2W x 2^WIN_LOG2H window once per frame and publishes it on rin_out,
// which feeds the red-input PIO. rin_out changes at most once per frame.
// Optional build macro RIN_FRAME_CHECK_EN: flags frames whose eop is not the last
// pixel (and sop restarts mid-frame) via frame_err instead of publishing them.
module rin_window_sampler #(
  parameter int IMG_W     = 640,
  parameter int IMG_H     = 480,
  parameter int WIN_X0    = 304,
  parameter int WIN_Y0    = 224,
  parameter int WIN_LOG2W = 5,
  parameter int WIN_LOG2H = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 capture_en,
  rin_window_sampler_if.slave  pix,
  output logic [9:0]           rin_out,
  output logic                 frame_done,
  output logic [15:0]          frame_cnt,
  output logic                 frame_err
);

  localparam int SH = WIN_LOG2W + WIN_LOG2H;
  localparam int AW = 10 + SH;

  // Window bounds widened to 13 bits so the exclusive upper edge never wraps.
  localparam logic [12:0] X0 = 13'(WIN_X0);
  localparam logic [12:0] X1 = 13'(WIN_X0 + (1 << WIN_LOG2W));
  localparam logic [12:0] Y0 = 13'(WIN_Y0);
  localparam logic [12:0] Y1 = 13'(WIN_Y0 + (1 << WIN_LOG2H));
  localparam logic [11:0] LAST_X = 12'(IMG_W - 1);

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_PUBLISH} state_t;

  state_t         state_q, state_d;
  logic [AW-1:0]  acc_q, acc_d;
  logic [11:0]    x_q, x_d, y_q, y_d;
  logic [9:0]     rin_out_q, rin_out_d;
  logic           frame_done_q, frame_done_d;
  logic [15:0]    frame_cnt_q, frame_cnt_d;

  logic           beat, start, step, fin;
  logic [11:0]    px, py;
  logic [AW-1:0]  r_ext;
  logic           unused_gb;

  function automatic logic in_win(input logic [11:0] x, input logic [11:0] y);
    return ({1'b0, x} >= X0) && ({1'b0, x} < X1) &&
           ({1'b0, y} >= Y0) && ({1'b0, y} < Y1);
  endfunction

  assign unused_gb = ^pix.pix_data[19:0];
  assign r_ext     = {{(AW-10){1'b0}}, pix.pix_data[29:20]};

  // Sink is ready except during the single PUBLISH cycle and while in reset.
  assign pix.pix_ready = !reset && (state_q != S_PUBLISH);
  assign beat          = pix.pix_valid && pix.pix_ready;

  // A sop starts a frame from IDLE only when capturing; in ACTIVE it always restarts.
  assign start = beat && pix.pix_sop &&
                 (((state_q == S_IDLE) && capture_en) || (state_q == S_ACTIVE));
  assign step  = beat && !pix.pix_sop && (state_q == S_ACTIVE);
  assign fin   = (start || step) && pix.pix_eop;
  // Coordinates of the pixel carried by this beat.
  assign px    = start ? 12'd0 : x_q;
  assign py    = start ? 12'd0 : y_q;

`ifdef RIN_FRAME_CHECK_EN
  localparam logic [11:0] LAST_Y = 12'(IMG_H - 1);
  logic err_pend_q, err_pend_d;
  logic frame_err_q, frame_err_d;
  logic eop_ok;

  assign eop_ok    = (px == LAST_X) && (py == LAST_Y);
  assign frame_err = frame_err_q;
`else
  assign frame_err = 1'b0;
`endif

  // Next-state: window accumulation, pixel counters and once-per-frame publish.
  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    x_d          = x_q;
    y_d          = y_q;
    rin_out_d    = rin_out_q;
    frame_done_d = 1'b0;
    frame_cnt_d  = frame_cnt_q;
`ifdef RIN_FRAME_CHECK_EN
    // Error pulse lands one edge after the offending beat, aligned with frame_done timing.
    frame_err_d  = err_pend_q;
    err_pend_d   = (start && (state_q == S_ACTIVE)) || (fin && !eop_ok);
`endif

    if (state_q == S_PUBLISH) begin
      rin_out_d    = acc_q[AW-1:SH];
      frame_done_d = 1'b1;
      frame_cnt_d  = frame_cnt_q + 16'd1;
      state_d      = S_IDLE;
    end else begin
      if (start) begin
        x_d     = 12'd1;
        y_d     = 12'd0;
        acc_d   = in_win(12'd0, 12'd0) ? r_ext : '0;
        state_d = S_ACTIVE;
      end else if (step) begin
        if (in_win(x_q, y_q)) acc_d = acc_q + r_ext;
        if (x_q == LAST_X) begin
          x_d = 12'd0;
          y_d = y_q + 12'd1;
        end else begin
          x_d = x_q + 12'd1;
        end
      end

      if (fin) begin
`ifdef RIN_FRAME_CHECK_EN
        state_d = eop_ok ? S_PUBLISH : S_IDLE;
`else
        state_d = S_PUBLISH;
`endif
      end
    end
  end

  // State and registered outputs; async reset discards any partial frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      acc_q        <= '0;
      x_q          <= '0;
      y_q          <= '0;
      rin_out_q    <= '0;
      frame_done_q <= 1'b0;
      frame_cnt_q  <= '0;
`ifdef RIN_FRAME_CHECK_EN
      err_pend_q   <= 1'b0;
      frame_err_q  <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      x_q          <= x_d;
      y_q          <= y_d;
      rin_out_q    <= rin_out_d;
      frame_done_q <= frame_done_d;
      frame_cnt_q  <= frame_cnt_d;
`ifdef RIN_FRAME_CHECK_EN
      err_pend_q   <= err_pend_d;
      frame_err_q  <= frame_err_d;
`endif
    end
  end

  assign rin_out    = rin_out_q;
  assign frame_done = frame_done_q;
  assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_rin_window_sampler.sv
// Randomized bench for rin_window_sampler on a reduced 16x12 image with a 4x4 window.
// The reference model computes each frame's expected average directly from the
// pixel values it sends and queues expected publish/error events with their cycle.
module tb_rin_window_sampler;
  localparam int W   = 16;
  localparam int H   = 12;
  localparam int WX0 = 4;
  localparam int WY0 = 3;
  localparam int LW  = 2;
  localparam int LH  = 2;

  typedef struct {
    bit     err;
    int     val;
    int     cnt;
    longint cyc;
  } ev_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        capture_en = 1'b0;
  logic [9:0]  rin_out;
  logic        frame_done;
  logic [15:0] frame_cnt;
  logic        frame_err;

  rin_window_sampler_if ifc();

  rin_window_sampler #(
    .IMG_W(W), .IMG_H(H), .WIN_X0(WX0), .WIN_Y0(WY0), .WIN_LOG2W(LW), .WIN_LOG2H(LH)
  ) dut (
    .clk(clk), .reset(reset), .capture_en(capture_en), .pix(ifc),
    .rin_out(rin_out), .frame_done(frame_done), .frame_cnt(frame_cnt), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int     n_chk = 0;
  int     n_fail = 0;
  longint cyc = 0;
  ev_t    evq[$];
  int     model_cnt = 0;
  bit     in_frame = 0;
  bit     mon_off = 1;
  logic [9:0] prev_rin = '0;
  logic       prev_ready = 1'b0;
  int     rv[W*H];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Output monitor: every publish/error pulse must match the next queued expectation.
  always @(negedge clk) begin
    if (!mon_off) begin
      chk("rin_stable", ((rin_out != prev_rin) && !frame_done) ? 64'd1 : 64'd0, 64'd0);
      if (frame_done || frame_err) begin
        if (evq.size() == 0) begin
          chk("unexpected_event", 64'd1, 64'd0);
        end else begin
          ev_t e;
          e = evq.pop_front();
          chk("event_is_err", {63'd0, frame_err}, {63'd0, e.err});
          chk("event_cycle", cyc, e.cyc);
          if (!e.err) begin
            chk("rin_out", {54'd0, rin_out}, 64'(e.val));
            chk("frame_cnt", {48'd0, frame_cnt}, 64'(e.cnt & 16'hFFFF));
            chk("ready_in_publish", {63'd0, prev_ready}, 64'd0);
          end
        end
      end
    end
    prev_rin   = rin_out;
    prev_ready = ifc.pix_ready;
  end

  function automatic bit in_win(input int x, input int y);
    return x >= WX0 && x < WX0 + (1 << LW) && y >= WY0 && y < WY0 + (1 << LH);
  endfunction

  // rmode: 0 constant rc, 1 R = x, 2 random R. Sends npix beats starting with sop.
  task automatic send_frame(input int npix, input int rmode, input int rc, input bit cap_sop,
                            input bit cap_drop, input int gap, input bit eop_en);
    int sum = 0;
    for (int p = 0; p < W*H; p++) begin
      case (rmode)
        0:       rv[p] = rc;
        1:       rv[p] = (p % W) & 10'h3FF;
        default: rv[p] = int'($urandom_range(1023));
      endcase
      if (p < npix && in_win(p % W, p / W)) sum += rv[p];
    end
    for (int p = 0; p < npix; p++) begin
      int t = 0;
      int g = 0;
      while (gap > 0 && g < 20 && int'($urandom_range(99)) < gap) begin
        @(negedge clk);
        ifc.pix_valid = 1'b0;
        ifc.pix_data  = 30'($urandom);
        g++;
      end
      @(negedge clk);
      ifc.pix_valid = 1'b1;
      ifc.pix_data  = {10'(rv[p]), 20'($urandom)};
      ifc.pix_sop   = (p == 0);
      ifc.pix_eop   = eop_en && (p == npix - 1);
      capture_en    = (p == 0) ? cap_sop : (cap_drop ? 1'b0 : cap_sop);
      while (!ifc.pix_ready) begin
        @(negedge clk);
        t++;
        if (t > 50) begin
          chk("ready_timeout", 64'd1, 64'd0);
          ifc.pix_valid = 1'b0;
          return;
        end
      end
      // Beat is accepted at the coming edge; its pulses appear one edge later.
      if (p == 0 && cap_sop) begin
`ifdef RIN_FRAME_CHECK_EN
        if (in_frame) evq.push_back('{err: 1'b1, val: 0, cnt: 0, cyc: cyc + 2});
`endif
        in_frame = 1;
      end
      if (p == npix - 1 && eop_en && cap_sop) begin
        in_frame = 0;
`ifdef RIN_FRAME_CHECK_EN
        if (npix != W*H) evq.push_back('{err: 1'b1, val: 0, cnt: 0, cyc: cyc + 2});
        else begin
          model_cnt++;
          evq.push_back('{err: 1'b0, val: sum >> (LW + LH), cnt: model_cnt, cyc: cyc + 2});
        end
`else
        model_cnt++;
        evq.push_back('{err: 1'b0, val: sum >> (LW + LH), cnt: model_cnt, cyc: cyc + 2});
`endif
      end
    end
    @(negedge clk);
    ifc.pix_valid = 1'b0;
    ifc.pix_sop   = 1'b0;
    ifc.pix_eop   = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && evq.size() != 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk("events_drained", 64'(evq.size()), 64'd0);
  endtask

  initial begin
    ifc.pix_valid = 1'b0;
    ifc.pix_sop   = 1'b0;
    ifc.pix_eop   = 1'b0;
    ifc.pix_data  = '0;
    #1;
    chk("rst_ready", {63'd0, ifc.pix_ready}, 64'd0);
    chk("rst_rin", {54'd0, rin_out}, 64'd0);
    chk("rst_done", {63'd0, frame_done}, 64'd0);
    chk("rst_cnt", {48'd0, frame_cnt}, 64'd0);
    chk("rst_err", {63'd0, frame_err}, 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    mon_off = 0;
    chk("idle_ready", {63'd0, ifc.pix_ready}, 64'd1);

    send_frame(W*H, 0, 100, 1, 0, 0, 1);           // constant 100
    send_frame(W*H, 1, 0,   1, 0, 0, 1);           // R = x
    send_frame(W*H, 0, 1023, 1, 0, 0, 1);          // back-to-back 1023 then 0
    send_frame(W*H, 0, 0,   1, 0, 0, 1);
    drain();
    chk("cnt_after_four", {48'd0, frame_cnt}, 64'(model_cnt));
    send_frame(W*H, 0, 512, 1, 0, 50, 1);          // ~50% valid gaps
    send_frame(W*H, 0, 77,  0, 0, 0, 1);           // capture disabled: ignored
    send_frame(W*H, 0, 200, 1, 1, 0, 1);           // capture dropped mid-frame
    send_frame(W*H, 2, 0,   1, 0, 30, 1);          // random R with gaps
    send_frame(30,  2, 0,   1, 0, 0, 0);           // abandoned by next sop
    send_frame(W*H, 2, 0,   1, 0, 0, 1);
    send_frame(6*W + 6, 2, 0, 1, 0, 0, 1);         // eop at (5,6)
    drain();
    chk("cnt_before_reset", {48'd0, frame_cnt}, 64'(model_cnt));

    // Reset in the middle of a frame discards it and clears outputs.
    send_frame(40, 0, 300, 1, 0, 0, 0);
    mon_off = 1;
    #2 reset = 1'b1;
    #1;
    chk("midrst_rin", {54'd0, rin_out}, 64'd0);
    chk("midrst_cnt", {48'd0, frame_cnt}, 64'd0);
    chk("midrst_ready", {63'd0, ifc.pix_ready}, 64'd0);
    evq.delete();
    model_cnt = 0;
    in_frame  = 0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    mon_off = 0;
    send_frame(W*H, 0, 100, 1, 0, 0, 1);
    drain();
    chk("cnt_final", {48'd0, frame_cnt}, 64'(model_cnt));
    chk("rin_final", {54'd0, rin_out}, 64'd100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
